// File: rtl/pre_if_stage_pkg.sv
// Shared constants and FSM encoding for the pre-IF fetch stage.
package pre_if_stage_pkg;
  localparam logic [31:0] PC_RESET    = 32'h1BFF_FFFC;
  localparam int          PF2FS_BUS_W = 65;
  localparam int          BR_ZIP_W    = 33;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, ADEF} pf_state_t;
endpackage

// File: rtl/pre_if_stage_fetch_out_buf.sv
// One-entry output register between pre-IF and IF with synchronous flush.
module fetch_out_buf
  import pre_if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [PF2FS_BUS_W-1:0] in_data,
  input  logic                   out_allowin,
  output logic                   out_valid,
  output logic [PF2FS_BUS_W-1:0] out_data
);
  // A load wins over flush: the only load that can coincide with a redirect
  // is the adef bundle for the redirect target itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (flush || out_allowin) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: next-PC selection, SRAM-like instruction fetch, redirect handling.
module pre_if_stage #(
  parameter logic [31:0] PC_RESET = pre_if_stage_pkg::PC_RESET
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  output logic                                    inst_sram_req,
  output logic                                    inst_sram_wr,
  output logic [1:0]                              inst_sram_size,
  output logic [3:0]                              inst_sram_wstrb,
  output logic [31:0]                             inst_sram_wdata,
  output logic [31:0]                             inst_sram_addr,
  input  logic                                    inst_sram_addr_ok,
  input  logic                                    inst_sram_data_ok,
  input  logic [31:0]                             inst_sram_rdata,
  input  logic                                    fs_allowin,
  output logic                                    pf2fs_valid,
  output logic [pre_if_stage_pkg::PF2FS_BUS_W-1:0] pf2fs_bus,
  input  logic [pre_if_stage_pkg::BR_ZIP_W-1:0]    br_zip,
  input  logic                                    wb_ex,
  input  logic [31:0]                             ex_entry,
  input  logic                                    ertn_flush,
  input  logic [31:0]                             ertn_entry
);
  import pre_if_stage_pkg::*;

  pf_state_t   state;
  logic [31:0] pc, redir_pc, addr_r, npc, redir_tgt;
  logic        redir_v, discard;
  logic        br_taken, redir_now, misalign, buf_valid, buf_ready, idle_issue;
  logic        load_adef, load_data;
  logic [31:0] br_target;
  logic [PF2FS_BUS_W-1:0] buf_in;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign {br_taken, br_target} = br_zip;
  assign redir_now = wb_ex | ertn_flush | br_taken;

  always_comb begin
    redir_tgt = br_target;
    if (wb_ex)           redir_tgt = ex_entry;
    else if (ertn_flush) redir_tgt = ertn_entry;
  end

  assign npc        = redir_now ? redir_tgt : (redir_v ? redir_pc : pc + 32'd4);
  assign misalign   = npc[1:0] != 2'b00;
  assign buf_ready  = ~buf_valid | fs_allowin | redir_now;
  assign idle_issue = (state == IDLE) & ~misalign & buf_ready;

  // Bus outputs are forced to their reset values while resetn is low.
  assign inst_sram_req  = resetn & ((state == WAIT_ADDR) | idle_issue);
  assign inst_sram_addr = !resetn ? 32'h0 : ((state == IDLE) ? npc : addr_r);

  // A response arriving together with a redirect is already wrong-path.
  assign load_adef = (state == IDLE) & misalign;
  assign load_data = (state == WAIT_DATA) & inst_sram_data_ok & ~discard & ~redir_now;
  assign buf_in    = load_adef ? {32'h0, npc, 1'b1} : {inst_sram_rdata, pc, 1'b0};

  fetch_out_buf u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (redir_now),
    .in_valid   (load_adef | load_data),
    .in_data    (buf_in),
    .out_allowin(fs_allowin),
    .out_valid  (buf_valid),
    .out_data   (pf2fs_bus)
  );

  assign pf2fs_valid = buf_valid & ~redir_now;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pc       <= PC_RESET;
      redir_v  <= 1'b0;
      redir_pc <= 32'h0;
      discard  <= 1'b0;
      addr_r   <= 32'h0;
    end else begin
      // In IDLE the redirect is forwarded into npc, so it is consumed directly.
      if (redir_now && state != IDLE) begin
        redir_v  <= 1'b1;
        redir_pc <= redir_tgt;
      end
      if (redir_now && (state == WAIT_ADDR || state == WAIT_DATA))
        discard <= 1'b1;
      case (state)
        IDLE: begin
          if (misalign) begin
            pc      <= npc;
            redir_v <= 1'b0;
            state   <= ADEF;
          end else if (buf_ready) begin
            redir_v <= 1'b0;
            addr_r  <= npc;
            if (inst_sram_addr_ok) begin
              pc    <= npc;
              state <= WAIT_DATA;
            end else begin
              state <= WAIT_ADDR;
            end
          end
        end
        WAIT_ADDR: if (inst_sram_addr_ok) begin
          pc    <= addr_r;
          state <= WAIT_DATA;
        end
        WAIT_DATA: if (inst_sram_data_ok) begin
          discard <= 1'b0;
          state   <= IDLE;
        end
        ADEF: if (wb_ex) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pre_if_stage.sv
// Scoreboard bench for pre_if_stage: directed redirect/stall/reset scenarios.
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata, inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        fs_allowin = 1'b1, pf2fs_valid;
  logic [64:0] pf2fs_bus;
  logic [32:0] br_zip = 33'h0;
  logic        wb_ex = 1'b0, ertn_flush = 1'b0;
  logic [31:0] ex_entry = 32'h0, ertn_entry = 32'h0;

  pre_if_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .fs_allowin(fs_allowin),
    .pf2fs_valid(pf2fs_valid), .pf2fs_bus(pf2fs_bus), .br_zip(br_zip),
    .wb_ex(wb_ex), .ex_entry(ex_entry), .ertn_flush(ertn_flush), .ertn_entry(ertn_entry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [64:0] exp_bun[$];
  logic [31:0] exp_addr[$];
  int          lat_q[$];
  int  n_acc = 0, wcnt = 0, dcnt = 0, dlat = 0, aok_delay = 0, dok_delay = 0;
  bit  pend = 0, stall = 0;
  logic [31:0] pend_addr = 32'h0, hold_addr = 32'h0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: no event within 200 cycles", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 200; i++) begin
      if (n_acc >= n) return;
      step();
    end
    timeout("wait_accept");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      if (pf2fs_valid) return;
      step();
    end
    timeout("wait_valid");
  endtask

  task automatic wait_second_wait_cycle();
    for (int i = 0; i < 200; i++) begin
      if (inst_sram_req && wcnt == 1) return;
      step();
    end
    timeout("wait_addr_stall");
  endtask

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Monitor (bundle scoreboard) and SRAM responder, both at the falling edge.
  always @(negedge clk) begin
    if (resetn && pf2fs_valid && fs_allowin) begin
      if (exp_bun.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL bundle_unexpected: got %h expected none", pf2fs_bus);
      end else chk("bundle", pf2fs_bus, exp_bun.pop_front());
      if (lat_q.size() != 0) chk("latency", 65'(cyc), 65'(lat_q.pop_front() + 2));
    end
    if (!resetn) begin
      pend = 0; wcnt = 0; dcnt = 0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
    end else begin
      inst_sram_data_ok = 1'b0;
      if (pend) begin
        if (dcnt >= dlat) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = sram_word(pend_addr);
          pend = 0;
        end else dcnt++;
      end
      inst_sram_addr_ok = 1'b0;
      if (inst_sram_req && !stall) begin
        if (wcnt > 0) chk("addr_stable", inst_sram_addr, hold_addr);
        hold_addr = inst_sram_addr;
        if (wcnt >= aok_delay) begin
          inst_sram_addr_ok = 1'b1;
          if (exp_addr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req_unexpected: got %h expected none", inst_sram_addr);
          end else chk("req_addr", inst_sram_addr, exp_addr.pop_front());
          pend = 1; pend_addr = inst_sram_addr; dcnt = 0; dlat = dok_delay;
          wcnt = 0; aok_delay = 0; dok_delay = 0;
          n_acc++;
          if (n_acc <= 4) lat_q.push_back(cyc);
        end else wcnt++;
      end
    end
  end

  initial begin
    // Reset values and constant bus fields.
    repeat (3) step();
    #3;
    chk("rst_req", inst_sram_req, 1'b0);
    chk("rst_addr", inst_sram_addr, 32'h0);
    chk("rst_valid", pf2fs_valid, 1'b0);
    chk("rst_bus", pf2fs_bus, 65'h0);
    chk("const_wr", inst_sram_wr, 1'b0);
    chk("const_size", inst_sram_size, 2'b10);
    chk("const_wstrb", inst_sram_wstrb, 4'h0);
    chk("const_wdata", inst_sram_wdata, 32'h0);

    // Sequential fetch, zero-wait SRAM.
    exp_addr.push_back(32'h1C00_0000); exp_bun.push_back({32'h0000_FFFF, 32'h1C00_0000, 1'b0});
    exp_addr.push_back(32'h1C00_0004); exp_bun.push_back({32'h0004_FFFB, 32'h1C00_0004, 1'b0});
    exp_addr.push_back(32'h1C00_0008); exp_bun.push_back({32'h0008_FFF7, 32'h1C00_0008, 1'b0});
    exp_addr.push_back(32'h1C00_000C); exp_bun.push_back({32'h000C_FFF3, 32'h1C00_000C, 1'b0});
    step();
    resetn = 1'b1;
    wait_acc(4);

    // addr_ok stalled 3 cycles, branch in the 2nd wait cycle: old addr held, data dropped.
    exp_addr.push_back(32'h1C00_0010);
    exp_addr.push_back(32'h1C00_0100);
    aok_delay = 3;
    wait_second_wait_cycle();
    br_zip = {1'b1, 32'h1C00_0100};
    step();
    br_zip = 33'h0;
    wait_acc(5);
    dok_delay = 2;

    // wb_ex beats br_taken in WAIT_DATA; the 1C000100 response is discarded.
    exp_addr.push_back(32'h1C00_8000); exp_bun.push_back({32'h8000_7FFF, 32'h1C00_8000, 1'b0});
    wait_acc(6);
    wb_ex = 1'b1; ex_entry = 32'h1C00_8000; br_zip = {1'b1, 32'h1C00_0200};
    step();
    wb_ex = 1'b0; br_zip = 33'h0;

    // IF backpressure: bundle held, no request; release transfers and issues together.
    wait_acc(7);
    fs_allowin = 1'b0;
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("hold_valid", pf2fs_valid, 1'b1);
      chk("hold_no_req", inst_sram_req, 1'b0);
      step();
    end
    exp_addr.push_back(32'h1C00_8004);
    fs_allowin = 1'b1;
    #3;
    chk("release_valid", pf2fs_valid, 1'b1);
    chk("release_req", inst_sram_req, 1'b1);
    chk("release_addr", inst_sram_addr, 32'h1C00_8004);
    step();

    // Misaligned branch while the 8004 bundle waits: bundle killed, adef bundle instead.
    wait_valid();
    exp_bun.push_back({32'h0, 32'h1C00_0102, 1'b1});
    br_zip = {1'b1, 32'h1C00_0102};
    #3;
    chk("redir_gates_valid", pf2fs_valid, 1'b0);
    chk("misalign_no_req", inst_sram_req, 1'b0);
    step();
    br_zip = 33'h0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("adef_no_req", inst_sram_req, 1'b0);
      step();
    end
    exp_addr.push_back(32'h1C00_A000);
    dok_delay = 3;
    wb_ex = 1'b1; ex_entry = 32'h1C00_A000;
    step();
    wb_ex = 1'b0;

    // Reset pulse during WAIT_DATA, then fetch restarts from 1C000000.
    wait_acc(9);
    resetn = 1'b0;
    #3;
    chk("midrst_req", inst_sram_req, 1'b0);
    chk("midrst_addr", inst_sram_addr, 32'h0);
    chk("midrst_valid", pf2fs_valid, 1'b0);
    chk("midrst_bus", pf2fs_bus, 65'h0);
    exp_addr.push_back(32'h1C00_0000); exp_bun.push_back({32'h0000_FFFF, 32'h1C00_0000, 1'b0});
    exp_addr.push_back(32'h1C00_0004); exp_bun.push_back({32'h0004_FFFB, 32'h1C00_0004, 1'b0});
    step();
    step();
    resetn = 1'b1;
    wait_acc(11);
    stall = 1;
    for (int i = 0; i < 200 && exp_bun.size() != 0; i++) step();
    repeat (3) step();
    chk("addr_queue_drained", 65'(exp_addr.size()), 65'd0);
    chk("bundle_queue_drained", 65'(exp_bun.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
